// File: rtl/writeback_stage_if.sv
// MEM->WB bundle: retiring-instruction fields in, register-file write port and status out.
interface writeback_stage_if #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) ();
  logic              wb_en;
  logic              flush;
  logic              mem_valid;
  logic              mem_writeReg;
  logic [REG_W-1:0]  mem_rw;
  logic [1:0]        mem_RWDSel;
  logic [WORD_W-1:0] mem_aluout;
  logic [WORD_W-1:0] mem_dmemload;
  logic [WORD_W-1:0] mem_PCInc;
  logic [15:0]       mem_imm16;
  logic              mem_halt;

  logic              writeReg;
  logic [REG_W-1:0]  rw;
  logic [WORD_W-1:0] dataout;
  logic              wb_valid;
  logic              halt;
  logic [CNT_W-1:0]  retired;

  modport master (
    output wb_en, flush, mem_valid, mem_writeReg, mem_rw, mem_RWDSel,
           mem_aluout, mem_dmemload, mem_PCInc, mem_imm16, mem_halt,
    input  writeReg, rw, dataout, wb_valid, halt, retired
  );

  modport slave (
    input  wb_en, flush, mem_valid, mem_writeReg, mem_rw, mem_RWDSel,
           mem_aluout, mem_dmemload, mem_PCInc, mem_imm16, mem_halt,
    output writeReg, rw, dataout, wb_valid, halt, retired
  );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with write-back data mux, sticky halt FSM and retired counter.
module writeback_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic             CLK,
  input  logic             RST,
  writeback_stage_if.slave wb
);
  typedef enum logic {RUN, HALTED} state_e;

  state_e            state_q;
  logic              writeReg_q, writeReg_d;
  logic [REG_W-1:0]  rw_q;
  logic [WORD_W-1:0] dataout_q, dataout_d;
  logic              wb_valid_q, wb_valid_d;
  logic              halt_q;
  logic [CNT_W-1:0]  retired_q;

  always_comb begin
    dataout_d = wb.mem_aluout;
    case (wb.mem_RWDSel)
      2'b00:   dataout_d = wb.mem_aluout;
      2'b01:   dataout_d = wb.mem_dmemload;
      2'b10:   dataout_d = wb.mem_PCInc;
      default: dataout_d = WORD_W'({wb.mem_imm16, 16'h0000});
    endcase
    // Once halted nothing else retires; HALT itself never writes a register.
    wb_valid_d = wb.mem_valid & (state_q == RUN);
    writeReg_d = wb_valid_d & wb.mem_writeReg & (wb.mem_rw != '0) & ~wb.mem_halt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= RUN;
      writeReg_q <= 1'b0;
      rw_q       <= '0;
      dataout_q  <= '0;
      wb_valid_q <= 1'b0;
      halt_q     <= 1'b0;
      retired_q  <= '0;
    end else if (wb.flush) begin
      // Bubble: clears the write port but leaves halt state and counter alone.
      writeReg_q <= 1'b0;
      rw_q       <= '0;
      dataout_q  <= '0;
      wb_valid_q <= 1'b0;
    end else if (wb.wb_en) begin
      writeReg_q <= writeReg_d;
      rw_q       <= wb.mem_rw;
      dataout_q  <= dataout_d;
      wb_valid_q <= wb_valid_d;
      if (wb_valid_d)
        retired_q <= retired_q + CNT_W'(1);
      case (state_q)
        RUN: if (wb.mem_valid && wb.mem_halt) begin
          state_q <= HALTED;
          halt_q  <= 1'b1;
        end
        default: begin
          state_q <= HALTED;
          halt_q  <= 1'b1;
        end
      endcase
    end
  end

  assign wb.writeReg = writeReg_q;
  assign wb.rw       = rw_q;
  assign wb.dataout  = dataout_q;
  assign wb.wb_valid = wb_valid_q;
  assign wb.halt     = halt_q;
  assign wb.retired  = retired_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage; a 4-bit-counter twin shares the stimulus to show wrap.
module tb_writeback_stage;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  writeback_stage_if #(.WORD_W(32), .REG_W(5), .CNT_W(32)) ifm ();
  writeback_stage_if #(.WORD_W(32), .REG_W(5), .CNT_W(4))  ifs ();

  writeback_stage #(.WORD_W(32), .REG_W(5), .CNT_W(32)) u_dut (.CLK(CLK), .RST(RST), .wb(ifm));
  writeback_stage #(.WORD_W(32), .REG_W(5), .CNT_W(4))  u_small (.CLK(CLK), .RST(RST), .wb(ifs));

  assign ifs.wb_en        = ifm.wb_en;
  assign ifs.flush        = ifm.flush;
  assign ifs.mem_valid    = ifm.mem_valid;
  assign ifs.mem_writeReg = ifm.mem_writeReg;
  assign ifs.mem_rw       = ifm.mem_rw;
  assign ifs.mem_RWDSel   = ifm.mem_RWDSel;
  assign ifs.mem_aluout   = ifm.mem_aluout;
  assign ifs.mem_dmemload = ifm.mem_dmemload;
  assign ifs.mem_PCInc    = ifm.mem_PCInc;
  assign ifs.mem_imm16    = ifm.mem_imm16;
  assign ifs.mem_halt     = ifm.mem_halt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk_all(input string tag, input logic wr, input logic [4:0] rw,
                         input logic [31:0] d, input logic v, input logic h,
                         input logic [31:0] ret);
    chk({tag, ".writeReg"}, 32'(ifm.writeReg), 32'(wr));
    chk({tag, ".rw"},       32'(ifm.rw),       32'(rw));
    chk({tag, ".dataout"},  ifm.dataout,       d);
    chk({tag, ".wb_valid"}, 32'(ifm.wb_valid), 32'(v));
    chk({tag, ".halt"},     32'(ifm.halt),     32'(h));
    chk({tag, ".retired"},  ifm.retired,       ret);
  endtask

  initial begin
    ifm.wb_en = 0; ifm.flush = 0; ifm.mem_valid = 0; ifm.mem_writeReg = 0;
    ifm.mem_rw = 0; ifm.mem_RWDSel = 0; ifm.mem_aluout = 0; ifm.mem_dmemload = 0;
    ifm.mem_PCInc = 0; ifm.mem_imm16 = 0; ifm.mem_halt = 0;

    // Reset state
    tick(); tick();
    chk_all("reset", 0, 0, 32'h0, 0, 0, 0);
    RST = 0;

    // 1: ALU write
    ifm.wb_en = 1; ifm.mem_valid = 1; ifm.mem_writeReg = 1; ifm.mem_rw = 8;
    ifm.mem_RWDSel = 2'b00; ifm.mem_aluout = 32'hDEADBEEF; ifm.mem_dmemload = 32'h12345678;
    ifm.mem_PCInc = 32'h104; ifm.mem_imm16 = 16'hABCD;
    tick();
    chk_all("t1_alu", 1, 8, 32'hDEADBEEF, 1, 0, 1);

    // 2: remaining mux selects
    ifm.mem_RWDSel = 2'b01; tick();
    chk_all("t2_load", 1, 8, 32'h12345678, 1, 0, 2);
    ifm.mem_RWDSel = 2'b10; tick();
    chk_all("t2_pcinc", 1, 8, 32'h00000104, 1, 0, 3);
    ifm.mem_RWDSel = 2'b11; tick();
    chk_all("t2_lui", 1, 8, 32'hABCD0000, 1, 0, 4);

    // 3: write to $0 suppressed but still retires
    ifm.mem_rw = 0; ifm.mem_RWDSel = 2'b00; tick();
    chk_all("t3_r0", 0, 0, 32'hDEADBEEF, 1, 0, 5);

    // 4: stall holds everything while inputs move
    ifm.wb_en = 0;
    ifm.mem_rw = 9; ifm.mem_aluout = 32'h1111; tick();
    chk_all("t4_hold0", 0, 0, 32'hDEADBEEF, 1, 0, 5);
    ifm.mem_valid = 0; ifm.mem_RWDSel = 2'b01; tick();
    chk_all("t4_hold1", 0, 0, 32'hDEADBEEF, 1, 0, 5);
    ifm.mem_halt = 1; ifm.mem_valid = 1; tick();
    chk_all("t4_hold2", 0, 0, 32'hDEADBEEF, 1, 0, 5);
    ifm.mem_halt = 0;
    ifm.flush = 1; tick();
    chk_all("t4_flush_noen", 0, 0, 32'h0, 0, 0, 5);

    // flush beats a capture of a valid HALT: no halt, no retire
    ifm.wb_en = 1; ifm.mem_halt = 1; ifm.mem_rw = 4; tick();
    chk_all("flush_over_en", 0, 0, 32'h0, 0, 0, 5);
    ifm.flush = 0; ifm.mem_halt = 0;

    // invalid capture: index/data captured, no write, no retire
    ifm.mem_valid = 0; ifm.mem_rw = 7; ifm.mem_RWDSel = 2'b00; ifm.mem_aluout = 32'hCAFE0000;
    tick();
    chk_all("invalid_cap", 0, 7, 32'hCAFE0000, 0, 0, 5);

    // async reset between edges, then counter wrap on the 4-bit twin
    #2 RST = 1; #2 RST = 0;
    chk_all("async_rst_a", 0, 0, 32'h0, 0, 0, 0);
    ifm.mem_valid = 1; ifm.mem_rw = 1;
    for (int i = 0; i < 15; i++) tick();
    chk("wrap_small_15", 32'(ifs.retired), 32'd15);
    chk("wrap_main_15", ifm.retired, 32'd15);
    tick();
    chk("wrap_small_0", 32'(ifs.retired), 32'd0);
    chk("wrap_main_16", ifm.retired, 32'd16);

    // 5: HALT retires, then everything after is suppressed
    ifm.mem_halt = 1; ifm.mem_rw = 5; tick();
    chk_all("t5_halt", 0, 5, 32'hCAFE0000, 1, 1, 17);
    ifm.mem_halt = 0; ifm.mem_rw = 3; ifm.mem_aluout = 32'h33; tick();
    chk_all("t5_after", 0, 3, 32'h33, 0, 1, 17);
    ifm.flush = 1; tick();
    chk_all("t5_flush_halted", 0, 0, 32'h0, 0, 1, 17);
    ifm.flush = 0;

    // 6: reset mid-stream clears immediately and discards the pending capture
    #2 RST = 1; #1;
    chk_all("t6_rst_async", 0, 0, 32'h0, 0, 0, 0);
    tick();
    chk_all("t6_rst_held", 0, 0, 32'h0, 0, 0, 0);
    RST = 0;
    ifm.mem_rw = 6; tick();
    chk_all("t6_after_rst", 1, 6, 32'h33, 1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
